serial_sub_ctrl: RTL

- Bit-serial N-bit subtractor controller. It time-shares one full_subt cell (ports a, b, c, d, bo) across all operand bits, one bit per clock, LSB first.
- Accepts a start request with operands, sequences the cell over WIDTH cycles and carries the borrow between cycles in a register.
- Presents the final difference, borrow-out and flags with a one-cycle done pulse.
- Sits between a control unit and the shared subtractor cell.

---
 rtl/serial_sub_ctrl_if.sv | 15 +
 rtl/serial_sub_ctrl.sv | 70 +++++++
 2 files changed

// File: rtl/serial_sub_ctrl_if.sv
// serial_sub_ctrl_if: request/result bundle between a control unit and the serial subtractor
interface serial_sub_ctrl_if #(parameter int WIDTH = 8);
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;
   logic             zero;
   modport master (output start, a_in, b_in, bin, input busy, done, diff, bout, ovf, zero);
   modport slave  (input start, a_in, b_in, bin, output busy, done, diff, bout, ovf, zero);
endinterface

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial subtractor sequencing one full-subtractor cell LSB first
module serial_sub_ctrl #(
   parameter int WIDTH = 8,
   parameter int CW    = 4
) (
   input logic              clk,
   input logic              rst,
   serial_sub_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state, state_nx;
   logic [WIDTH-1:0] a_sr, b_sr, diff_r, diff_nx;
   logic [CW-1:0]    count;
   logic             borrow, a_msb, b_msb, bout_r, ovf_r, zero_r;
   logic             d, bo, last;
   // shared full_subt cell: d = a - b - c, bo = borrow out of this bit
   assign d       = a_sr[0] ^ b_sr[0] ^ borrow;
   assign bo      = (~a_sr[0] & (b_sr[0] | borrow)) | (b_sr[0] & borrow);
   assign last    = count == CW'(WIDTH - 1);
   assign diff_nx = {d, diff_r[WIDTH-1:1]};
   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nx;
   // next-state: IDLE waits for start, RUN lasts WIDTH cycles, DONE lasts one
   always_comb
      state_nx = (state == IDLE) ? (bus.start ? RUN : IDLE) :
                 (state == RUN)  ? (last ? DONE : RUN) : IDLE;
   // outputs: status decoded from state, results from held registers
   always_comb begin
      bus.busy = state == RUN;
      bus.done = state == DONE;
      bus.diff = diff_r;
      bus.bout = bout_r;
      bus.ovf  = ovf_r;
      bus.zero = zero_r;
   end
   // datapath: load operands on start, one bit per RUN cycle, flags captured on the last bit
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         diff_r <= '0;
         count  <= '0;
         borrow <= 1'b0;
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         bout_r <= 1'b0;
         ovf_r  <= 1'b0;
         zero_r <= 1'b0;
      end else if (state == IDLE && bus.start) begin
         a_sr   <= bus.a_in;
         b_sr   <= bus.b_in;
         a_msb  <= bus.a_in[WIDTH-1];
         b_msb  <= bus.b_in[WIDTH-1];
         borrow <= bus.bin;
         count  <= '0;
      end else if (state == RUN) begin
         diff_r <= diff_nx;
         borrow <= bo;
         a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
         b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
         count  <= count + 1'b1;
         if (last) begin
            bout_r <= bo;
            ovf_r  <= (a_msb != b_msb) && (d != a_msb);
            zero_r <= diff_nx == '0;
         end
      end
endmodule
